multi_alarm_clock: RTL

Parametrised successor to the single-alarm clock top level. The block is a time-of-day and day-of-week counter chain with NA independently settable alarms and a shared ring/snooze/auto-off state machine. It outputs binary time and display-select values for the existing 2-digit lcd_int drivers, plus Buzz. It sits between the five manual buttons and the display drivers.

---
 rtl/multi_alarm_clock.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_alarm_clock.sv
// Time-of-day / day-of-week clock with NA alarms sharing one ring/snooze FSM.
// Optional HOUR12_EN: 12-hour time display plus a Pm output.
module multi_alarm_clock #(
   parameter int NS         = 60,
   parameter int NM         = 60,
   parameter int NH         = 24,
   parameter int ND         = 7,
   parameter int NA         = 2,
   parameter int SNOOZE_MIN = 9,
   parameter int BUZZ_MAX   = 60,
   parameter int AW         = (NA > 1) ? $clog2(NA) : 1
) (
   input  logic          Pulse,
   input  logic          Reset,
   input  logic          Timeset,
   input  logic          Alarmset,
   input  logic [AW-1:0] Alarmsel,
   input  logic          Minadv,
   input  logic          Hrsadv,
   input  logic          Dayadv,
   input  logic [NA-1:0] Alarmon,
   input  logic          Snooze,
   input  logic          Stop,
   output logic [6:0]    TSec,
   output logic [2:0]    TDay,
   output logic [6:0]    DispMin,
   output logic [6:0]    DispHrs,
   output logic [AW-1:0] RingIdx,
   output logic [1:0]    State,
   output logic          Buzz
`ifdef HOUR12_EN
   ,
   output logic          Pm
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } state_t;

   localparam logic [6:0]  NS_M1  = 7'(NS - 1);
   localparam logic [6:0]  NM_M1  = 7'(NM - 1);
   localparam logic [6:0]  NH_M1  = 7'(NH - 1);
   localparam logic [2:0]  ND_M1  = 3'(ND - 1);
   localparam logic [7:0]  BZ_M1  = 8'(BUZZ_MAX - 1);
   localparam logic [12:0] SNZ_LD = 13'(SNOOZE_MIN * NS - 1);
   localparam logic [AW:0] NA_W   = (AW + 1)'(NA);

   logic [6:0]    sec_q, sec_d, min_q, min_d, hrs_q, hrs_d;
   logic [2:0]    day_q, day_d;
   logic [6:0]    amin_q [NA];
   logic [6:0]    amin_d [NA];
   logic [6:0]    ahrs_q [NA];
   logic [6:0]    ahrs_d [NA];
   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d, win, dsel;
   logic [7:0]    bcnt_q, bcnt_d;
   logic [12:0]   scnt_q, scnt_d;
   logic          smax, min_top, hrs_top, trig, sel_ok;
   logic [6:0]    dhrs;

   assign smax    = !Timeset && (sec_q == NS_M1);
   assign min_top = (min_q == NM_M1);
   assign hrs_top = (hrs_q == NH_M1);
   assign sel_ok  = ({1'b0, Alarmsel} < NA_W);

   // Set-mode advances wrap in place and never carry into the next field.
   always_comb begin
      sec_d = sec_q;
      min_d = min_q;
      hrs_d = hrs_q;
      day_d = day_q;
      if (!Timeset)
         sec_d = smax ? 7'd0 : sec_q + 7'd1;
      if (smax || (Timeset && Minadv))
         min_d = min_top ? 7'd0 : min_q + 7'd1;
      if ((smax && min_top) || (Timeset && Hrsadv))
         hrs_d = hrs_top ? 7'd0 : hrs_q + 7'd1;
      if ((smax && min_top && hrs_top) || (Timeset && Dayadv))
         day_d = (day_q == ND_M1) ? 3'd0 : day_q + 3'd1;
   end

   always_comb begin
      amin_d = amin_q;
      ahrs_d = ahrs_q;
      if (Alarmset && !Timeset && sel_ok) begin
         if (Minadv)
            amin_d[Alarmsel] = (amin_q[Alarmsel] == NM_M1) ?
                               7'd0 : amin_q[Alarmsel] + 7'd1;
         if (Hrsadv)
            ahrs_d[Alarmsel] = (ahrs_q[Alarmsel] == NH_M1) ?
                               7'd0 : ahrs_q[Alarmsel] + 7'd1;
      end
   end

   // Descending scan so the lowest matching index wins.
   always_comb begin
      trig = 1'b0;
      win  = '0;
      for (int i = NA - 1; i >= 0; i--) begin
         if (Alarmon[i] && !Timeset && sec_q == 7'd0 &&
             min_q == amin_q[i] && hrs_q == ahrs_q[i]) begin
            trig = 1'b1;
            win  = AW'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      bcnt_d  = bcnt_q;
      scnt_d  = scnt_q;
      if (trig) begin
         state_d = RING;
         idx_d   = win;
         bcnt_d  = '0;
      end else begin
         unique case (state_q)
            RING: begin
               if (Stop || !Alarmon[idx_q]) begin
                  state_d = IDLE;
               end else if (Snooze) begin
                  state_d = SNOOZE;
                  scnt_d  = SNZ_LD;
               end else if (bcnt_q == BZ_M1) begin
                  state_d = IDLE;
               end else begin
                  bcnt_d = bcnt_q + 8'd1;
               end
            end
            SNOOZE: begin
               if (Stop || !Alarmon[idx_q]) begin
                  state_d = IDLE;
               end else if (scnt_q == '0) begin
                  state_d = RING;
                  bcnt_d  = '0;
               end else begin
                  scnt_d = scnt_q - 13'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Pulse or posedge Reset) begin
      if (Reset) begin
         sec_q   <= '0;
         min_q   <= '0;
         hrs_q   <= '0;
         day_q   <= '0;
         amin_q  <= '{default: '0};
         ahrs_q  <= '{default: '0};
         state_q <= IDLE;
         idx_q   <= '0;
         bcnt_q  <= '0;
         scnt_q  <= '0;
      end else begin
         sec_q   <= sec_d;
         min_q   <= min_d;
         hrs_q   <= hrs_d;
         day_q   <= day_d;
         amin_q  <= amin_d;
         ahrs_q  <= ahrs_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         bcnt_q  <= bcnt_d;
         scnt_q  <= scnt_d;
      end
   end

   assign dsel    = sel_ok ? Alarmsel : '0;
   assign DispMin = Alarmset ? amin_q[dsel] : min_q;
   assign dhrs    = Alarmset ? ahrs_q[dsel] : hrs_q;
   assign TSec    = sec_q;
   assign TDay    = day_q;
   assign RingIdx = idx_q;
   assign State   = state_q;
   assign Buzz    = (state_q == RING);

`ifdef HOUR12_EN
   if (NH != 24) begin : g_nh_chk
      $error("HOUR12_EN requires NH == 24");
   end

   always_comb begin
      DispHrs = dhrs;
      if (!Alarmset) begin
         if (hrs_q == 7'd0)
            DispHrs = 7'd12;
         else if (hrs_q > 7'd12)
            DispHrs = hrs_q - 7'd12;
         else
            DispHrs = hrs_q;
      end
   end

   assign Pm = (dhrs >= 7'd12);
`else
   assign DispHrs = dhrs;
`endif

endmodule
